// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared op-select encodings, sequencer state type and default
//               datapath width for the alu32 command sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam int DEFAULT_WIDTH = 32;

  // alu32 op-select encodings
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_XOR = 3'b010;
  localparam logic [2:0] ALU_ADD = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b100;
  localparam logic [2:0] ALU_SLL = 3'b101;
  localparam logic [2:0] ALU_SRL = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/alu_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : alu_watchdog
// Description : Clearable up-counter with a terminal-count flag that fires
//               when the count reaches TIMEOUT-1.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam int CW = $clog2(TIMEOUT);

  logic [CW-1:0] r_count;

  // Count enabled wait cycles; clear takes priority over counting.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign terminal = (r_count == CW'(TIMEOUT - 1));

endmodule
`default_nettype wire

// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_cmd_sequencer
// Description : Initiator side of the alu32 start/done handshake. Takes one
//               command at a time, pulses start, waits for done (or watchdog
//               timeout) and returns the result on a valid/ready port.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [2:0]       cmd_sel,
  output logic             alu_start,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic [2:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_done,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_err,
  output logic [CNT_W-1:0] op_count
);

  seq_state_t       r_state;
  seq_state_t       w_next;
  logic             r_cmd_ready;
  logic             r_alu_start;
  logic [WIDTH-1:0] r_alu_in1;
  logic [WIDTH-1:0] r_alu_in2;
  logic [2:0]       r_alu_sel;
  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_result;
  logic             r_rsp_err;
  logic [CNT_W-1:0] r_op_count;
  logic             w_wd_term;
  logic             w_wd_clear;
  logic             w_wd_enable;

  // Watchdog restarts on the start cycle and only runs while waiting for done.
  assign w_wd_clear  = (r_state == ST_ISSUE);
  assign w_wd_enable = (r_state == ST_WAIT) && !alu_done && !w_wd_term;

  alu_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .clear    (w_wd_clear),
    .enable   (w_wd_enable),
    .terminal (w_wd_term)
  );

  // Next-state decode; done beats a coincident watchdog expiry.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (cmd_valid) w_next = ST_ISSUE;
      ST_ISSUE: w_next = ST_WAIT;
      ST_WAIT:  if (alu_done || w_wd_term) w_next = ST_RESP;
      ST_RESP:  if (rsp_ready) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // State register plus registered outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_cmd_ready  <= 1'b1;
      r_alu_start  <= 1'b0;
      r_alu_in1    <= '0;
      r_alu_in2    <= '0;
      r_alu_sel    <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_err    <= 1'b0;
      r_op_count   <= '0;
    end else begin
      r_state     <= w_next;
      r_cmd_ready <= (w_next == ST_IDLE);
      r_alu_start <= (w_next == ST_ISSUE);
      r_rsp_valid <= (w_next == ST_RESP);
      if (r_state == ST_IDLE && cmd_valid) begin
        r_alu_in1 <= cmd_a;
        r_alu_in2 <= cmd_b;
        r_alu_sel <= cmd_sel;
      end
      if (r_state == ST_WAIT) begin
        if (alu_done) begin
          r_rsp_result <= alu_result;
          r_rsp_err    <= 1'b0;
          r_op_count   <= r_op_count + CNT_W'(1);
        end else if (w_wd_term) begin
          r_rsp_result <= '0;
          r_rsp_err    <= 1'b1;
        end
      end
    end
  end

  assign cmd_ready  = r_cmd_ready;
  assign alu_start  = r_alu_start;
  assign alu_in1    = r_alu_in1;
  assign alu_in2    = r_alu_in2;
  assign alu_sel    = r_alu_sel;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_rsp_result;
  assign rsp_err    = r_rsp_err;
  assign op_count   = r_op_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_cmd_sequencer
// Description : Randomized self-checking bench for alu_cmd_sequencer with a
//               behavioural alu32 responder and a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_cmd_sequencer;
  import alu_pkg::*;

  localparam int W    = 32;
  localparam int TMO  = 8;
  localparam int CNTW = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic [W-1:0]    cmd_a = '0;
  logic [W-1:0]    cmd_b = '0;
  logic [2:0]      cmd_sel = '0;
  logic            alu_start;
  logic [W-1:0]    alu_in1;
  logic [W-1:0]    alu_in2;
  logic [2:0]      alu_sel;
  logic [W-1:0]    alu_result;
  logic            alu_done;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [W-1:0]    rsp_result;
  logic            rsp_err;
  logic [CNTW-1:0] op_count;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int starts = 0;
  int prev_acc = 0;
  int exp_cnt = 0;

  // alu32 behavioural responder state
  int           alu_lat = 1;
  int           m_cnt = 0;
  logic         m_done = 1'b0;
  logic         spur_done = 1'b0;
  logic [W-1:0] junk = '0;

  alu_cmd_sequencer #(.WIDTH(W), .TIMEOUT(TMO), .CNT_W(CNTW)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel),
    .alu_start(alu_start), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_sel(alu_sel),
    .alu_result(alu_result), .alu_done(alu_done),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_err(rsp_err), .op_count(op_count)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [2:0] sel);
    case (sel)
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_XOR: return a ^ b;
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_SLL: return a << b[4:0];
      ALU_SRL: return a >> b[4:0];
      default: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    endcase
  endfunction

  // done is high on the alu_lat-th cycle after start; 0 means never
  assign alu_done   = m_done | spur_done;
  assign alu_result = m_done ? alu_ref(alu_in1, alu_in2, alu_sel) : junk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (alu_start) starts <= starts + 1;
  end

  always @(negedge clk) begin
    junk = $urandom;
    if (reset) begin
      m_cnt = 0; m_done = 1'b0;
    end else if (alu_start) begin
      m_cnt = alu_lat; m_done = 1'b0;
    end else if (m_cnt > 0) begin
      m_cnt = m_cnt - 1; m_done = (m_cnt == 0);
    end else begin
      m_done = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_alu_start", alu_start, 0);
    chk("rst_alu_in1", alu_in1, 0);
    chk("rst_alu_in2", alu_in2, 0);
    chk("rst_alu_sel", alu_sel, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_op_count", op_count, 0);
  endtask

  // One full command/response transaction, starting and ending on a negedge.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] sel,
                        input int lat, input int hold, input bit spur, input bit chk_period);
    int n;
    int s0;
    logic err_e;
    logic [W-1:0] res_e;
    err_e = (lat == 0) || (lat > TMO);
    res_e = err_e ? '0 : alu_ref(a, b, sel);
    if (!err_e) exp_cnt = (exp_cnt + 1) % (1 << CNTW);
    chk("cmd_ready_idle", cmd_ready, 1);
    alu_lat = lat;
    s0 = starts;
    cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_sel = sel;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_a = $urandom; cmd_b = $urandom;
    if (chk_period) chk("op_period", cyc - prev_acc, 4);
    prev_acc = cyc;
    chk("issue_start", alu_start, 1);
    chk("issue_cmd_ready", cmd_ready, 0);
    chk("issue_in1", alu_in1, a);
    chk("issue_in2", alu_in2, b);
    chk("issue_sel", alu_sel, sel);
    n = 1;
    while (!rsp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_latency", n, err_e ? TMO + 2 : lat + 2);
    chk("start_pulses", starts - s0, 1);
    if (rsp_valid) begin
      chk("rsp_result", rsp_result, res_e);
      chk("rsp_err", rsp_err, err_e);
      chk("op_count", op_count, exp_cnt);
      for (int i = 0; i < hold; i++) begin
        if (spur && i == 0) spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        chk("hold_valid", rsp_valid, 1);
        chk("hold_result", rsp_result, res_e);
        chk("hold_err", rsp_err, err_e);
        chk("hold_cmd_ready", cmd_ready, 0);
        chk("hold_op_count", op_count, exp_cnt);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("post_rsp_valid", rsp_valid, 0);
      chk("post_cmd_ready", cmd_ready, 1);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_cnt = 0;
    check_reset_outputs();
  endtask

  initial begin
    int saw_valid;
    @(negedge clk);
    do_reset();

    // directed AND vector, done one cycle after start
    run_op(32'h42220225, 32'h4002028A, ALU_AND, 1, 0, 1'b0, 1'b0);
    // backpressure with a spurious done during the response
    run_op(32'h12345678, 32'h00000003, ALU_SUB, 2, 10, 1'b1, 1'b0);
    // no done at all -> timeout
    run_op(32'hDEADBEEF, 32'h0F0F0F0F, ALU_XOR, 0, 2, 1'b0, 1'b0);
    // done on the terminal watchdog cycle wins
    run_op(32'h00000005, 32'hFFFFFFFE, ALU_SLT, TMO, 1, 1'b0, 1'b0);
    // done one cycle too late -> timeout, late done lands in RESP
    run_op(32'h00000001, 32'h00000004, ALU_SLL, TMO + 1, 3, 1'b0, 1'b0);

    // reset in the middle of WAIT
    alu_lat = 5;
    cmd_valid = 1'b1; cmd_a = 32'hAAAA5555; cmd_b = 32'h1; cmd_sel = ALU_ADD;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    do_reset();
    saw_valid = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rsp_valid) saw_valid = 1;
    end
    chk("no_rsp_after_reset", saw_valid, 0);
    run_op(32'h0000FFFF, 32'h00000010, ALU_SRL, 1, 0, 1'b0, 1'b0);

    // randomized traffic
    for (int k = 0; k < 30; k++) begin
      run_op($urandom, $urandom, 3'($urandom_range(0, 7)), $urandom_range(0, TMO + 2),
             $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0);
    end

    // 17 back-to-back successes wrap a 4-bit counter to 1
    do_reset();
    for (int k = 0; k < 17; k++) begin
      run_op($urandom, $urandom, 3'($urandom_range(0, 7)), 1, 0, 1'b0, k != 0);
    end
    chk("wrap_op_count", op_count, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Initiator side of the alu32 start/done handshake.
- Accepts one operation at a time (operands plus 3-bit op select) from an upstream valid/ready command port.
- Drives alu32's start, in1, in2 and sel, waits for done, captures the result, and returns it on a valid/ready response port.
- A watchdog flags an ALU that never asserts done; a counter records completed operations. Sits between the control/test logic and alu32.

Parameters:
- WIDTH, 32, operand and result width.
- TIMEOUT, 64, maximum WAIT cycles before an error response (legal range 2..65535).
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  upstream command valid.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_a  in  WIDTH  operand A.
- cmd_b  in  WIDTH  operand B.
- cmd_sel  in  3  ALU op select (000 = AND, and the rest of the alu32 encoding).
- alu_start  out  1  one-cycle start pulse to alu32.
- alu_in1  out  WIDTH  to alu32 in1.
- alu_in2  out  WIDTH  to alu32 in2.
- alu_sel  out  3  to alu32 sel.
- alu_result  in  WIDTH  from alu32 result.
- alu_done  in  1  from alu32 done.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  downstream accepts the response.
- rsp_result  out  WIDTH  captured result, or 0 on timeout.
- rsp_err  out  1  1 = timeout, no done received.
- op_count  out  CNT_W  successful completions; wraps modulo 2^CNT_W.

Behaviour:
- Reset values: state IDLE; cmd_ready 1; alu_start 0; alu_in1, alu_in2, alu_sel 0; rsp_valid 0; rsp_result 0; rsp_err 0; op_count 0; watchdog 0.
- Reset mid-operation aborts any transaction next cycle. No response is produced for the aborted transaction.
- All outputs are registered.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid, latch cmd_a, cmd_b and cmd_sel into alu_in1, alu_in2 and alu_sel; go to ISSUE.
  - cmd_ready drops the cycle after acceptance.
- ISSUE:
  - alu_start = 1 for exactly this one cycle.
  - Watchdog cleared; go to WAIT.
- WAIT:
  - alu_start = 0. alu_in1, alu_in2 and alu_sel stay stable until WAIT exits.
  - If alu_done = 1: rsp_result <= alu_result, rsp_err <= 0, op_count <= op_count + 1; go to RESP.
  - Else if watchdog == TIMEOUT-1: rsp_result <= 0, rsp_err <= 1, op_count unchanged; go to RESP.
  - Else watchdog increments.
  - If alu_done and the timeout limit coincide, done wins.
- RESP:
  - rsp_valid = 1. rsp_result and rsp_err stay stable while rsp_ready = 0.
  - On rsp_ready: rsp_valid deasserts next cycle; go to IDLE.
- Ignored input: alu_done in IDLE, ISSUE or RESP. A late or spurious done does not alter the held response.
- Minimum latency:
  - Command accept to first rsp_valid cycle: 3 cycles, for an ALU whose done is seen the cycle after start (accept -> ISSUE -> WAIT -> RESP).
  - Back-to-back commands: minimum 4 cycles per operation, since there is no overlap.
- op_count wraps from 2^CNT_W-1 to 0 without an error.

Decomposition:
- Shared package alu_pkg holds:
  - the 3-bit op-select encodings (ALU_AND = 3'b000, and the rest);
  - the state enum for IDLE, ISSUE, WAIT, RESP;
  - the default WIDTH.
- One natural sub-module: alu_watchdog, a loadable/clearable counter with a terminal-count flag and TIMEOUT parameter.
- The top integrates with alu32 in the system wrapper, not inside this block.

Test Plan:
- AND, ALU model done latency 1:
  - Stimulus: cmd_a = 0x42220225, cmd_b = 0x4002028A, sel = 000, rsp_ready held 1.
  - Response: a single alu_start pulse; rsp_result = 0x40020200, rsp_err = 0; rsp_valid 3 cycles after accept; op_count = 1.
- Backpressure:
  - Stimulus: rsp_ready held 0 for 10 cycles, with a spurious alu_done pulse during RESP.
  - Response: rsp_valid stays 1 and the result is stable; cmd_ready stays 0; op_count is not double-counted.
- Timeout:
  - Stimulus: ALU model never asserts done, TIMEOUT = 8.
  - Response: rsp_valid with rsp_err = 1, rsp_result = 0; op_count unchanged.
- Done on the terminal watchdog cycle, TIMEOUT = 8:
  - Stimulus: done arrives on the 8th WAIT cycle.
  - Response: rsp_err = 0 and the result is captured.
- Reset in WAIT:
  - Stimulus: assert reset one cycle, mid-wait.
  - Response: all outputs at reset values the next cycle; no rsp_valid; the next command completes normally.
- op_count wrap:
  - Stimulus: CNT_W = 4, 17 successful operations back-to-back.
  - Response: op_count reads 1; each operation takes 4 cycles.
